top_keyboard: RTL and testbench

Keypad-driven 8-bit integer calculator top level. Decodes a 4×4 matrix keypad (row/column one-hot), debounces keys, and accumulates two decimal operands A and B. It then performs add, multiply or divide on the selected operation key and drives result and display-control flags to the display stage.

---
 rtl/top_keyboard_pkg.sv | 74 +++++++
 rtl/div_restoring.sv | 88 ++++++++
 rtl/top_keyboard.sv | 251 +++++++++++++++++++++++++
 tb/tb_top_keyboard.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/top_keyboard_pkg.sv
// Shared types and keypad decode for the keypad calculator.
//   state_e     : calculator sequencing states
//   key_e       : decoded key codes (digits, letter keys, '*', '#', no key)
//   decode_key  : rows/columns one-hot pair -> key code (KNone when not a clean press)
package top_keyboard_pkg;

  typedef enum logic [2:0] {
    StEnterA,
    StEnterB,
    StWaitOp,
    StDivide,
    StResult
  } state_e;

  // Digits occupy codes 0..9 so the code doubles as the digit value.
  typedef enum logic [4:0] {
    K0, K1, K2, K3, K4, K5, K6, K7, K8, K9,
    KA, KB, KC, KD,
    KStar, KHash, KNone
  } key_e;

  localparam logic [3:0] RowTop = 4'b1000;  // 1 2 3 A
  localparam logic [3:0] Row2   = 4'b0100;  // 4 5 6 B
  localparam logic [3:0] Row3   = 4'b0010;  // 7 8 9 C
  localparam logic [3:0] RowBot = 4'b0001;  // * 0 # D

  localparam logic [3:0] Col0 = 4'b0001;
  localparam logic [3:0] Col1 = 4'b0010;
  localparam logic [3:0] Col2 = 4'b0100;
  localparam logic [3:0] Col3 = 4'b1000;

  // Indexed by {row index, column index}, row 0 = top row.
  localparam key_e KeyMap [16] = '{
    K1,    K2, K3,    KA,
    K4,    K5, K6,    KB,
    K7,    K8, K9,    KC,
    KStar, K0, KHash, KD
  };

  function automatic key_e decode_key(input logic [3:0] rows, input logic [3:0] cols);
    logic [1:0] r;
    logic [1:0] c;
    logic       ok;
    ok = 1'b1;
    r  = 2'd0;
    c  = 2'd0;
    case (rows)
      RowTop:  r = 2'd0;
      Row2:    r = 2'd1;
      Row3:    r = 2'd2;
      RowBot:  r = 2'd3;
      default: ok = 1'b0;
    endcase
    case (cols)
      Col0:    c = 2'd0;
      Col1:    c = 2'd1;
      Col2:    c = 2'd2;
      Col3:    c = 2'd3;
      default: ok = 1'b0;
    endcase
    return ok ? KeyMap[{r, c}] : KNone;
  endfunction

  function automatic logic is_digit(input key_e k);
    return k <= K9;
  endfunction

  function automatic logic [3:0] key_digit(input key_e k);
    logic [4:0] raw;
    raw = k;
    return raw[3:0];
  endfunction

endpackage

// File: rtl/div_restoring.sv
// 8-bit restoring divider, one quotient bit per cycle.
//   start_i       : load operands and begin (restarts an in-flight division)
//   dividend_i    : dividend, sampled with start_i
//   divisor_i     : divisor, sampled with start_i
//   done_o        : one-cycle pulse, results valid from this cycle on
//   quotient_o    : quotient (all ones when dividing by zero)
//   remainder_o   : remainder (equals the dividend when dividing by zero)
//   div_by_zero_o : the loaded divisor was zero
module div_restoring (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] dividend_i,
  input  logic [7:0] divisor_i,
  output logic       done_o,
  output logic [7:0] quotient_o,
  output logic [7:0] remainder_o,
  output logic       div_by_zero_o
);

  logic [7:0] quo_q, quo_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] dvs_q, dvs_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [8:0] shifted;
  logic [8:0] diff;

  // The partial remainder stays below the divisor, so 8 bits hold it; with a zero divisor
  // it is a prefix of the dividend, which also fits.
  assign shifted = {rem_q, quo_q[7]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = 8'd0;
      dvs_d  = divisor_i;
      cnt_d  = 4'd8;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!diff[8]) begin
        rem_d = diff[7:0];
        quo_d = {quo_q[6:0], 1'b1};
      end else begin
        rem_d = shifted[7:0];
        quo_d = {quo_q[6:0], 1'b0};
      end
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q  <= 8'd0;
      rem_q  <= 8'd0;
      dvs_q  <= 8'd0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o        = done_q;
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = (dvs_q == 8'd0);

endmodule

// File: rtl/top_keyboard.sv
// Keypad calculator: debounces a 4x4 matrix keypad, accumulates decimal operands A and B
// and computes A*B, A+B or A/B (quotient and remainder) on the chosen operation key.
//   clk, reset        : clock, asynchronous active-low reset
//   filas, columnas   : keypad row / column, one-hot when a key is pressed
//   A_dec, B_dec      : operands in binary
//   listo             : result valid
//   showA/showB       : display selects A entry / B entry (or waiting for an operation)
//   show_mult         : display shows the result
//   multi             : last operation was a multiply
//   suma              : A+B or A*B
//   cociente, residuo : A/B and A mod B (all ones / A when B is zero)
module top_keyboard
  import top_keyboard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  filas,
  input  logic [3:0]  columnas,
  output logic [7:0]  A_dec,
  output logic [7:0]  B_dec,
  output logic        listo,
  output logic        showA,
  output logic        showB,
  output logic        show_mult,
  output logic        multi,
  output logic [15:0] suma,
  output logic [15:0] cociente,
  output logic [15:0] residuo
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(DEBOUNCE_CYCLES);

  // ---------------- Debounce ----------------
  key_e raw_key;
  key_e cand_q, cand_d;      // last sampled code
  key_e stable_q, stable_d;  // accepted level: KNone (released) or the held key
  cnt_t cnt_q, cnt_d;        // consecutive samples equal to cand, saturating
  logic key_evt_q, key_evt_d;
  key_e key_code_q, key_code_d;

  assign raw_key = decode_key(filas, columnas);

  always_comb begin
    cand_d     = raw_key;
    stable_d   = stable_q;
    key_evt_d  = 1'b0;
    key_code_d = key_code_q;
    if (raw_key != cand_q) begin
      cnt_d = cnt_t'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // A press only counts out of the released level, and a different key replacing the
    // held one directly is not a release, so it produces no event.
    if (cnt_d == CntMax && raw_key != stable_q) begin
      if (stable_q == KNone) begin
        stable_d   = raw_key;
        key_evt_d  = 1'b1;
        key_code_d = raw_key;
      end else if (raw_key == KNone) begin
        stable_d = KNone;
      end
    end
  end

  // ---------------- Calculator sequencing ----------------
  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] suma_q, suma_d;
  logic [15:0] coc_q, coc_d;
  logic [15:0] res_q, res_d;
  logic        listo_q, listo_d;
  logic        multi_q, multi_d;
  logic        show_a_q, show_a_d;
  logic        show_b_q, show_b_d;
  logic        show_mult_q, show_mult_d;

  logic        div_start;
  logic        div_done;
  logic        div_by_zero;
  logic [7:0]  div_quo;
  logic [7:0]  div_rem;
  logic [3:0]  digit;
  logic [11:0] acc_a;
  logic [11:0] acc_b;

  assign digit = key_digit(key_code_q);
  assign acc_a = 12'(a_q) * 12'd10 + 12'(digit);
  assign acc_b = 12'(b_q) * 12'd10 + 12'(digit);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    suma_d    = suma_q;
    coc_d     = coc_q;
    res_d     = res_q;
    listo_d   = listo_q;
    multi_d   = multi_q;
    div_start = 1'b0;
    if (key_evt_q && key_code_q == KStar) begin
      state_d = StEnterA;
      a_d     = 8'd0;
      b_d     = 8'd0;
      suma_d  = 16'd0;
      coc_d   = 16'd0;
      res_d   = 16'd0;
      listo_d = 1'b0;
      multi_d = 1'b0;
    end else begin
      unique case (state_q)
        StEnterA: begin
          if (key_evt_q) begin
            if (is_digit(key_code_q)) begin
              if (acc_a <= 12'd255) a_d = acc_a[7:0];
            end else if (key_code_q == KA) begin
              state_d = StEnterB;
            end
          end
        end
        StEnterB: begin
          if (key_evt_q) begin
            if (is_digit(key_code_q)) begin
              if (acc_b <= 12'd255) b_d = acc_b[7:0];
            end else if (key_code_q == KA) begin
              state_d = StWaitOp;
            end
          end
        end
        StWaitOp: begin
          if (key_evt_q) begin
            case (key_code_q)
              KB: begin
                suma_d  = 16'(a_q) * 16'(b_q);
                multi_d = 1'b1;
                listo_d = 1'b1;
                state_d = StResult;
              end
              KC: begin
                suma_d  = 16'(a_q) + 16'(b_q);
                multi_d = 1'b0;
                listo_d = 1'b1;
                state_d = StResult;
              end
              KD: begin
                div_start = 1'b1;
                state_d   = StDivide;
              end
              default: ;
            endcase
          end
        end
        StDivide: begin
          if (div_done) begin
            coc_d   = div_by_zero ? 16'hFFFF : {8'h00, div_quo};
            res_d   = {8'h00, div_rem};
            multi_d = 1'b0;
            listo_d = 1'b1;
            state_d = StResult;
          end
        end
        StResult: begin
          if (key_evt_q && is_digit(key_code_q)) begin
            a_d     = {4'h0, digit};
            b_d     = 8'd0;
            suma_d  = 16'd0;
            coc_d   = 16'd0;
            res_d   = 16'd0;
            listo_d = 1'b0;
            multi_d = 1'b0;
            state_d = StEnterA;
          end
        end
        default: state_d = StEnterA;
      endcase
    end
    // Display flags are registered alongside the state so they change with it.
    show_a_d    = (state_d == StEnterA);
    show_b_d    = (state_d == StEnterB) || (state_d == StWaitOp);
    show_mult_d = (state_d == StResult);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q      <= KNone;
      stable_q    <= KNone;
      cnt_q       <= '0;
      key_evt_q   <= 1'b0;
      key_code_q  <= KNone;
      state_q     <= StEnterA;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      suma_q      <= 16'd0;
      coc_q       <= 16'd0;
      res_q       <= 16'd0;
      listo_q     <= 1'b0;
      multi_q     <= 1'b0;
      show_a_q    <= 1'b1;
      show_b_q    <= 1'b0;
      show_mult_q <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      key_evt_q   <= key_evt_d;
      key_code_q  <= key_code_d;
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      suma_q      <= suma_d;
      coc_q       <= coc_d;
      res_q       <= res_d;
      listo_q     <= listo_d;
      multi_q     <= multi_d;
      show_a_q    <= show_a_d;
      show_b_q    <= show_b_d;
      show_mult_q <= show_mult_d;
    end
  end

  div_restoring u_div (
    .clk_i        (clk),
    .rst_ni       (reset),
    .start_i      (div_start),
    .dividend_i   (a_q),
    .divisor_i    (b_q),
    .done_o       (div_done),
    .quotient_o   (div_quo),
    .remainder_o  (div_rem),
    .div_by_zero_o(div_by_zero)
  );

  assign A_dec     = a_q;
  assign B_dec     = b_q;
  assign listo     = listo_q;
  assign showA     = show_a_q;
  assign showB     = show_b_q;
  assign show_mult = show_mult_q;
  assign multi     = multi_q;
  assign suma      = suma_q;
  assign cociente  = coc_q;
  assign residuo   = res_q;

endmodule

// File: tb/tb_top_keyboard.sv
module tb_top_keyboard;

  localparam int unsigned Deb = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [7:0]  A_dec;
  logic [7:0]  B_dec;
  logic        listo;
  logic        showA;
  logic        showB;
  logic        show_mult;
  logic        multi;
  logic [15:0] suma;
  logic [15:0] cociente;
  logic [15:0] residuo;

  always #5 clk = ~clk;

  top_keyboard #(
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .filas    (filas),
    .columnas (columnas),
    .A_dec    (A_dec),
    .B_dec    (B_dec),
    .listo    (listo),
    .showA    (showA),
    .showB    (showB),
    .show_mult(show_mult),
    .multi    (multi),
    .suma     (suma),
    .cociente (cociente),
    .residuo  (residuo)
  );

  // {row, column} per key: 0..9 digits, 10..13 = A..D, 14 = '*', 15 = '#'
  logic [7:0] key_tab [16] = '{
    8'h12, 8'h81, 8'h82, 8'h84, 8'h41, 8'h42, 8'h44, 8'h21,
    8'h22, 8'h24, 8'h88, 8'h48, 8'h28, 8'h18, 8'h11, 8'h14
  };

  int n_chk = 0;
  int n_bad = 0;
  int n_keys = 0;

  // Reference model: mode 0 = entering A, 1 = entering B, 2 = waiting op, 3 = showing result
  int m_st, ma, mb, msum, mquo, mrem, mlisto, mmulti;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; ma = 0; mb = 0; msum = 0; mquo = 0; mrem = 0; mlisto = 0; mmulti = 0;
  endtask

  task automatic model_key(input int k);
    if (k == 14) begin
      model_reset();
    end else if (k != 15) begin
      case (m_st)
        0: if (k < 10) begin
             if (ma * 10 + k <= 255) ma = ma * 10 + k;
           end else if (k == 10) m_st = 1;
        1: if (k < 10) begin
             if (mb * 10 + k <= 255) mb = mb * 10 + k;
           end else if (k == 10) m_st = 2;
        2: if (k == 11) begin
             msum = ma * mb; mmulti = 1; mlisto = 1; m_st = 3;
           end else if (k == 12) begin
             msum = ma + mb; mmulti = 0; mlisto = 1; m_st = 3;
           end else if (k == 13) begin
             if (mb == 0) begin
               mquo = 65535; mrem = ma;
             end else begin
               mquo = ma / mb; mrem = ma % mb;
             end
             mmulti = 0; mlisto = 1; m_st = 3;
           end
        default: if (k < 10) begin
             model_reset(); ma = k;
           end
      endcase
    end
  endtask

  task automatic check_all(input string w);
    check_eq({w, ".A_dec"}, 32'(A_dec), 32'(ma));
    check_eq({w, ".B_dec"}, 32'(B_dec), 32'(mb));
    check_eq({w, ".suma"}, 32'(suma), 32'(msum));
    check_eq({w, ".cociente"}, 32'(cociente), 32'(mquo));
    check_eq({w, ".residuo"}, 32'(residuo), 32'(mrem));
    check_eq({w, ".listo"}, 32'(listo), 32'(mlisto));
    check_eq({w, ".multi"}, 32'(multi), 32'(mmulti));
    check_eq({w, ".showA"}, 32'(showA), 32'(m_st == 0));
    check_eq({w, ".showB"}, 32'(showB), 32'(m_st == 1 || m_st == 2));
    check_eq({w, ".show_mult"}, 32'(show_mult), 32'(m_st == 3));
  endtask

  // Any pattern that is not a clean one-hot row and column pair.
  task automatic drive_idle();
    logic [3:0] bad_cols [4] = '{4'b0000, 4'b0011, 4'b1111, 4'b0101};
    case ($urandom_range(0, 2))
      0: begin filas = 4'b0000; columnas = 4'($urandom_range(0, 15)); end
      1: begin filas = 4'b1111; columnas = 4'($urandom_range(0, 15)); end
      default: begin
        filas    = 4'b0001 << $urandom_range(0, 3);
        columnas = bad_cols[$urandom_range(0, 3)];
      end
    endcase
  endtask

  task automatic press_key(input int k);
    int kind;
    int lat;
    int hold;
    logic [7:0] rc;
    kind = 0;
    if (m_st == 2 && (k == 11 || k == 12)) kind = 1;
    if (m_st == 2 && k == 13) kind = 2;
    rc = key_tab[k];
    filas    = rc[7:4];
    columnas = rc[3:0];
    lat  = 0;
    hold = Deb + 14 + $urandom_range(0, 3);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (lat == 0 && listo) lat = i;
    end
    drive_idle();
    repeat (Deb + 3 + $urandom_range(0, 3)) @(negedge clk);
    model_key(k);
    n_keys++;
    // Event registered after Deb stable samples; add/multiply one cycle later.
    if (kind == 1) check_eq($sformatf("k%0d.lat_fast", n_keys), 32'(lat), 32'(Deb + 1));
    if (kind == 2) check_eq($sformatf("k%0d.lat_div_in_bound(lat=%0d)", n_keys, lat),
                            32'(lat > 0 && lat <= Deb + 10), 32'd1);
  endtask

  function automatic int char_to_key(input byte c);
    if (c >= "0" && c <= "9") return int'(c - "0");
    if (c >= "A" && c <= "D") return int'(c - "A") + 10;
    if (c == "*") return 14;
    return 15;
  endfunction

  task automatic run_seq(input string s);
    for (int i = 0; i < s.len(); i++) begin
      press_key(char_to_key(s[i]));
      check_all($sformatf("k%0d", n_keys));
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_seq("100A5AD");
    check_eq("plan1.cociente", 32'(cociente), 32'd20);
    check_eq("plan1.A", 32'(A_dec), 32'd100);
    run_seq("44A7AD");
    check_eq("plan2.residuo", 32'(residuo), 32'd2);
    run_seq("202A9AD");
    check_eq("plan3.cociente", 32'(cociente), 32'd22);
    run_seq("12A0AD");
    check_eq("plan4.cociente", 32'(cociente), 32'hFFFF);
    check_eq("plan4.residuo", 32'(residuo), 32'd12);
    run_seq("*256A");
    check_eq("plan5.A", 32'(A_dec), 32'd25);
    run_seq("*12A3AB");
    check_eq("plan6.suma", 32'(suma), 32'd36);
    run_seq("*12A3AC");
    check_eq("plan7.suma", 32'(suma), 32'd15);

    // Glitch one cycle short of the debounce window must be ignored.
    run_seq("*4");
    filas = 4'b0010; columnas = 4'b0001;  // '7'
    repeat (Deb - 1) @(negedge clk);
    drive_idle();
    repeat (Deb + 3) @(negedge clk);
    check_all("glitch");

    // Reset while the divider is running.
    run_seq("*200A3A");
    filas = 4'b0001; columnas = 4'b1000;  // 'D'
    repeat (Deb + 4) @(negedge clk);
    check_eq("div.showA", 32'(showA), 32'd0);
    check_eq("div.showB", 32'(showB), 32'd0);
    check_eq("div.show_mult", 32'(show_mult), 32'd0);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_in_div");
    drive_idle();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (Deb + 3) @(negedge clk);
    check_all("after_rst");

    // Random key traffic, biased toward digits, 'A' and the operation keys.
    for (int n = 0; n < 160; n++) begin
      int k;
      case ($urandom_range(0, 3))
        0, 1: k = $urandom_range(0, 9);
        2: k = $urandom_range(10, 13);
        default: k = $urandom_range(0, 15);
      endcase
      press_key(k);
      check_all($sformatf("k%0d", n_keys));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
